// File: rtl/sync_ram_sdp_pipelined.sv
// -----------------------------------------------------------------------------
// sync_ram_sdp_pipelined
// Simple dual-port RAM with one write port (A) and one read port (B).
// Writes use byte-lane enables. Reads are pipelined with a latency of 1 or 2
// cycles and deliver one result per cycle.
//
// Parameters
//   ADDR_WIDTH   : address width; depth = 2**ADDR_WIDTH words
//   DATA_WIDTH   : word width in bits
//   BYTE_WIDTH   : lane width; DATA_WIDTH must be a multiple of it
//   READ_LATENCY : 1 = output register only, 2 = array register + output register
//   RDW_MODE     : same-address read-during-write; 0 = old word, 1 = merged new word
//
// Ports
//   clk        : sole clock, rising edge
//   rst        : synchronous active-high reset (clears pipeline, keeps memory)
//   enA        : port A enable
//   writeA     : write strobe, qualified by enA
//   byteEnA    : per-lane write enable
//   addressA   : write address
//   writeDataA : write data
//   enB        : read request
//   addressB   : read address
//   readDataB  : registered read data, holds between results
//   readValidB : one-cycle pulse per returned result
// -----------------------------------------------------------------------------
module sync_ram_sdp_pipelined #(
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_WIDTH   = 32,
    parameter int BYTE_WIDTH   = 8,
    parameter int READ_LATENCY = 1,
    parameter int RDW_MODE     = 0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             enA,
    input  logic                             writeA,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] byteEnA,
    input  logic [ADDR_WIDTH-1:0]            addressA,
    input  logic [DATA_WIDTH-1:0]            writeDataA,
    input  logic                             enB,
    input  logic [ADDR_WIDTH-1:0]            addressB,
    output logic [DATA_WIDTH-1:0]            readDataB,
    output logic                             readValidB
);

    localparam int LANES = DATA_WIDTH / BYTE_WIDTH;
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    // Reject unsupported configurations at elaboration time.
    if ((DATA_WIDTH % BYTE_WIDTH) != 32'sd0) begin : g_bad_byte_width
        $error("DATA_WIDTH must be an integer multiple of BYTE_WIDTH");
    end
    if ((READ_LATENCY != 32'sd1) && (READ_LATENCY != 32'sd2)) begin : g_bad_latency
        $error("READ_LATENCY must be 1 or 2");
    end

    // Overlay the enabled lanes of new_word onto old_word.
    function automatic logic [DATA_WIDTH-1:0] merge_lanes(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] new_word,
        input logic [LANES-1:0]      lane_en
    );
        logic [DATA_WIDTH-1:0] result;
        result = old_word;
        for (int i = 0; i < LANES; i++) begin
            if (lane_en[i]) begin
                result[i*BYTE_WIDTH +: BYTE_WIDTH] = new_word[i*BYTE_WIDTH +: BYTE_WIDTH];
            end else begin
                result[i*BYTE_WIDTH +: BYTE_WIDTH] = old_word[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
        return result;
    endfunction

    // Memory array is intentionally never reset so contents survive rst.
    logic [DATA_WIDTH-1:0] mem_r [DEPTH];

    logic                  write_s;
    logic                  collide_s;
    logic [DATA_WIDTH-1:0] read_old_s;
    logic [DATA_WIDTH-1:0] read_word_s;

    // Decode write strobe and same-address collision, select the word a read returns.
    always_comb begin
        write_s     = enA & writeA & ~rst;
        collide_s   = write_s & enB & (addressA == addressB);
        read_old_s  = mem_r[addressB];
        read_word_s = read_old_s;
        // In new-data mode a colliding read sees the merged word the write produces.
        if ((RDW_MODE == 32'sd1) && collide_s) begin
            read_word_s = merge_lanes(read_old_s, writeDataA, byteEnA);
        end else begin
            read_word_s = read_old_s;
        end
    end

    // Per-lane memory write; lane-granular form maps onto byte-write RAM primitives.
    always_ff @(posedge clk) begin
        if (write_s) begin
            for (int i = 0; i < LANES; i++) begin
                if (byteEnA[i]) begin
                    mem_r[addressA][i*BYTE_WIDTH +: BYTE_WIDTH] <= writeDataA[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    if (READ_LATENCY == 32'sd1) begin : g_lat1
        // Single output register; data only updates when a result arrives.
        always_ff @(posedge clk) begin
            if (rst) begin
                readDataB  <= '0;
                readValidB <= 1'b0;
            end else begin
                readValidB <= enB;
                if (enB) begin
                    readDataB <= read_word_s;
                end
            end
        end
    end else begin : g_lat2
        logic                  stage_valid_r;
        logic [DATA_WIDTH-1:0] stage_data_r;

        // Array register then output register. The word is captured at the
        // request edge, so a later write to the same address cannot alter it.
        always_ff @(posedge clk) begin
            if (rst) begin
                stage_valid_r <= 1'b0;
                readDataB     <= '0;
                readValidB    <= 1'b0;
            end else begin
                stage_valid_r <= enB;
                if (enB) begin
                    stage_data_r <= read_word_s;
                end
                readValidB <= stage_valid_r;
                if (stage_valid_r) begin
                    readDataB <= stage_data_r;
                end
            end
        end
    end

endmodule

// File: tb/tb_sync_ram_sdp_pipelined.sv
// -----------------------------------------------------------------------------
// Bench for sync_ram_sdp_pipelined. Two instances share one stimulus stream:
//   dut0 : READ_LATENCY=1, RDW_MODE=0 (defaults)
//   dut1 : READ_LATENCY=2, RDW_MODE=1
// A behavioural model (word array with written-bit mask plus a queue of
// pending results with due edges) predicts both outputs every cycle;
// literal expectations pin the model at key points.
// -----------------------------------------------------------------------------
module tb_sync_ram_sdp_pipelined;

    logic        clk = 1'b0;
    logic        rst, enA, writeA, enB;
    logic [3:0]  byteEnA;
    logic [15:0] addressA, addressB;
    logic [31:0] writeDataA;
    logic [31:0] rd0, rd1;
    logic        rv0, rv1;

    always #5 clk = ~clk;

    sync_ram_sdp_pipelined dut0 (
        .clk(clk), .rst(rst), .enA(enA), .writeA(writeA), .byteEnA(byteEnA),
        .addressA(addressA), .writeDataA(writeDataA), .enB(enB),
        .addressB(addressB), .readDataB(rd0), .readValidB(rv0)
    );

    sync_ram_sdp_pipelined #(.READ_LATENCY(2), .RDW_MODE(1)) dut1 (
        .clk(clk), .rst(rst), .enA(enA), .writeA(writeA), .byteEnA(byteEnA),
        .addressA(addressA), .writeDataA(writeDataA), .enB(enB),
        .addressB(addressB), .readDataB(rd1), .readValidB(rv1)
    );

    typedef struct {
        int          due;
        logic [31:0] d;
        logic [31:0] m;
    } res_t;

    logic [31:0] mdata [int];
    logic [31:0] mmask [int];
    res_t        q0[$];
    res_t        q1[$];
    int          edgeN = 0;
    logic [31:0] heldD [2];
    logic [31:0] heldM [2];
    logic        expV  [2];
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp, input logic [31:0] m);
        checks++;
        if (((act ^ exp) & m) !== 32'h0) begin
            errors++;
            $display("FAIL %s: got %h expected %h (mask %h) edge %0d", nm, act, exp, m, edgeN);
        end
    endtask

    // Model of one rising edge, using the inputs currently applied.
    task automatic model_edge();
        logic [31:0] old, om, nw, nm;
        int a;
        edgeN++;
        if (rst) begin
            q0.delete();
            q1.delete();
            for (int c = 0; c < 2; c++) begin
                expV[c]  = 1'b0;
                heldD[c] = 32'h0;
                heldM[c] = 32'hFFFF_FFFF;
            end
            return;
        end
        if (enB) begin
            a  = int'(addressB);
            old = mdata.exists(a) ? mdata[a] : 32'h0;
            om  = mmask.exists(a) ? mmask[a] : 32'h0;
            nw = old;
            nm = om;
            if (enA && writeA && (addressA == addressB)) begin
                for (int i = 0; i < 4; i++) begin
                    if (byteEnA[i]) begin
                        nw[i*8 +: 8] = writeDataA[i*8 +: 8];
                        nm[i*8 +: 8] = 8'hFF;
                    end
                end
            end
            q0.push_back('{edgeN, old, om});       // latency 1, old data
            q1.push_back('{edgeN + 1, nw, nm});    // latency 2, merged data
        end
        if (enA && writeA) begin
            a  = int'(addressA);
            nw = mdata.exists(a) ? mdata[a] : 32'h0;
            nm = mmask.exists(a) ? mmask[a] : 32'h0;
            for (int i = 0; i < 4; i++) begin
                if (byteEnA[i]) begin
                    nw[i*8 +: 8] = writeDataA[i*8 +: 8];
                    nm[i*8 +: 8] = 8'hFF;
                end
            end
            mdata[a] = nw;
            mmask[a] = nm;
        end
        expV[0] = 1'b0;
        if (q0.size() > 0 && q0[0].due == edgeN) begin
            expV[0]  = 1'b1;
            heldD[0] = q0[0].d;
            heldM[0] = q0[0].m;
            void'(q0.pop_front());
        end
        expV[1] = 1'b0;
        if (q1.size() > 0 && q1[0].due == edgeN) begin
            expV[1]  = 1'b1;
            heldD[1] = q1[0].d;
            heldM[1] = q1[0].m;
            void'(q1.pop_front());
        end
    endtask

    task automatic compare_all();
        chk("valid0", {31'b0, rv0}, {31'b0, expV[0]}, 32'h1);
        chk("data0",  rd0, heldD[0], heldM[0]);
        chk("valid1", {31'b0, rv1}, {31'b0, expV[1]}, 32'h1);
        chk("data1",  rd1, heldD[1], heldM[1]);
    endtask

    task automatic step(input logic r, input logic eA, input logic wA,
                        input logic [3:0] be, input logic [15:0] aA,
                        input logic [31:0] dA, input logic eB, input logic [15:0] aB);
        rst = r; enA = eA; writeA = wA; byteEnA = be;
        addressA = aA; writeDataA = dA; enB = eB; addressB = aB;
        model_edge();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] be);
        step(1'b0, 1'b1, 1'b1, be, a, d, 1'b0, 16'h0);
    endtask
    task automatic rdq(input logic [15:0] a);
        step(1'b0, 1'b0, 1'b0, 4'h0, 16'h0, 32'h0, 1'b1, a);
    endtask
    task automatic wrrd(input logic [15:0] a, input logic [31:0] d, input logic [3:0] be,
                        input logic [15:0] ra);
        step(1'b0, 1'b1, 1'b1, be, a, d, 1'b1, ra);
    endtask
    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 4'h0, 16'h0, 32'h0, 1'b0, 16'h0);
    endtask
    task automatic rstc();
        step(1'b1, 1'b0, 1'b0, 4'h0, 16'h0, 32'h0, 1'b0, 16'h0);
    endtask

    // Literal expectation: checks the DUT and the model against a hand value.
    task automatic lit(input string nm, input int c, input logic v, input logic [31:0] d);
        chk({nm, "_v"}, {31'b0, (c == 0) ? rv0 : rv1}, {31'b0, v}, 32'h1);
        chk({nm, "_d"}, (c == 0) ? rd0 : rd1, d, 32'hFFFF_FFFF);
        chk({nm, "_model"}, heldD[c], d, 32'hFFFF_FFFF);
    endtask

    initial begin
        rstc(); rstc(); rstc();
        lit("rst0", 0, 1'b0, 32'h0);
        lit("rst1", 1, 1'b0, 32'h0);

        // Basic write then read
        wr(16'h0010, 32'hDEADBEEF, 4'hF);
        rdq(16'h0010);
        lit("basic0", 0, 1'b1, 32'hDEADBEEF);
        idle();
        lit("basic1", 1, 1'b1, 32'hDEADBEEF);
        lit("hold0",  0, 1'b0, 32'hDEADBEEF);

        // Byte enables
        wr(16'h0005, 32'h11223344, 4'hF);
        wr(16'h0005, 32'hAABBCCDD, 4'h5);
        rdq(16'h0005);
        idle();
        lit("be1", 1, 1'b1, 32'h11BB33DD);
        lit("be0", 0, 1'b0, 32'h11BB33DD);

        // Full-word collision
        wr(16'h0020, 32'h00000000, 4'hF);
        wrrd(16'h0020, 32'hCAFEF00D, 4'hF, 16'h0020);
        lit("col0", 0, 1'b1, 32'h00000000);
        idle();
        lit("col1", 1, 1'b1, 32'hCAFEF00D);

        // Partial-lane collision
        wrrd(16'h0020, 32'h12345678, 4'h3, 16'h0020);
        idle();
        lit("pcol1", 1, 1'b1, 32'hCAFE5678);
        lit("pcol0", 0, 1'b0, 32'hCAFEF00D);

        // Different-address write and read
        wrrd(16'h0040, 32'h55555555, 4'hF, 16'h0010);
        lit("diff0", 0, 1'b1, 32'hDEADBEEF);
        idle();

        // Back-to-back reads through the two-stage pipeline
        wr(16'h0000, 32'h10, 4'hF);
        wr(16'h0001, 32'h11, 4'hF);
        wr(16'h0002, 32'h12, 4'hF);
        wr(16'h0003, 32'h13, 4'hF);
        rdq(16'h0000);
        lit("ppre", 1, 1'b0, 32'hDEADBEEF);
        rdq(16'h0001);
        lit("p0", 1, 1'b1, 32'h10);
        rdq(16'h0002);
        lit("p1", 1, 1'b1, 32'h11);
        rdq(16'h0003);
        lit("p2", 1, 1'b1, 32'h12);
        idle();
        lit("p3", 1, 1'b1, 32'h13);
        idle();
        lit("pend", 1, 1'b0, 32'h13);

        // Write right after a read must not alter the in-flight result
        rdq(16'h0005);
        wr(16'h0005, 32'hFFFFFFFF, 4'hF);
        lit("inflight", 1, 1'b1, 32'h11BB33DD);
        idle();

        // Enabled without write strobe, and write with no lanes: no change
        step(1'b0, 1'b1, 1'b0, 4'hF, 16'h0000, 32'h0, 1'b0, 16'h0);
        step(1'b0, 1'b1, 1'b1, 4'h0, 16'h0001, 32'h0, 1'b0, 16'h0);
        rdq(16'h0000);
        rdq(16'h0001);
        lit("nc0", 1, 1'b1, 32'h10);
        idle();
        lit("nc1", 1, 1'b1, 32'h11);

        // Reset while a read is in flight; write and read during reset ignored
        rdq(16'h0010);
        step(1'b1, 1'b1, 1'b1, 4'hF, 16'h0010, 32'h0, 1'b1, 16'h0010);
        lit("mr1", 1, 1'b0, 32'h0);
        lit("mr0", 0, 1'b0, 32'h0);
        rstc();
        idle();
        idle();
        lit("mr1b", 1, 1'b0, 32'h0);
        rdq(16'h0010);
        idle();
        lit("surv", 1, 1'b1, 32'hDEADBEEF);

        // Highest address
        wr(16'hFFFF, 32'h0BADF00D, 4'hF);
        rdq(16'hFFFF);
        lit("max0", 0, 1'b1, 32'h0BADF00D);
        idle();
        lit("max1", 1, 1'b1, 32'h0BADF00D);

        // Never-written address: valid still pulses, data unconstrained
        rdq(16'h1234);
        idle();
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
